mips_int_ctrl: RTL and testbench
================================

Name: mips_int_ctrl

Overview:
- Multi-channel interrupt controller for mips_cpu. It generalises the single raw int0 line to NUM_IRQ sources.
- Each source has per-source mask, per-source edge/level mode, and fixed priority (lowest index wins).
- Request/acknowledge/end-of-interrupt handshake with the CPU; one interrupt in service at a time, no nesting.
- Sits between external interrupt pins and the CPU exception logic. Config registers are accessed through a small register port.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..32).
- ID_W, 3, width of int_id; must equal max(1, clog2(NUM_IRQ)).
- SYNC_STAGES, 2, synchroniser flops per irq_in bit (>=2).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- irq_in  in  NUM_IRQ  raw external interrupt lines, asynchronous to clk.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  0=mask, 1=mode, 2=pending (write-1-to-clear), 3=in_service (read-only).
- cfg_wdata  in  NUM_IRQ  config write data.
- cfg_rdata  out  NUM_IRQ  combinational readback of the register at cfg_addr.
- int_req  out  1  interrupt request to CPU, registered.
- int_id  out  ID_W  index of the requested source; stable while int_req=1.
- int_ack  in  1  single-cycle CPU accept pulse.
- int_eoi  in  1  single-cycle end-of-interrupt pulse (eret).

Behaviour:
- Reset values (async, immediate): sync flops 0, mask 0 (all masked), mode all-ones (edge), pending 0, in_service 0, state IDLE, int_req 0, int_id 0.
- Synchroniser: each irq_in bit passes through SYNC_STAGES flops, giving s. A further flop holds s_d.
- Edge mode (mode[i]=1):
  - pending[i] sets on s[i] & ~s_d[i].
  - Clears on ack of source i, or on a cfg W1C write.
  - If a set and a clear occur in the same cycle, set wins.
- Level mode (mode[i]=0):
  - pending[i] is registered s[i].
  - Ack and W1C have no effect; the source must deassert itself.
- Eligible vector: pending & mask. winner = lowest set index (mips_prio_enc).
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If eligible != 0 → REQ; next cycle int_req=1 and int_id=winner (latched).
  - int_ack and int_eoi are ignored.
- REQ:
  - int_id is frozen; a higher-priority arrival does not preempt.
  - int_ack → SERVICE: int_req=0, in_service[int_id]=1, edge-mode pending[int_id] cleared.
  - No ack and eligible[int_id]=0 (masked or cleared) → withdraw: int_req=0, return to IDLE.
  - Ack and withdrawal in the same cycle: ack wins.
  - int_eoi is ignored.
- SERVICE:
  - int_req=0.
  - int_eoi → in_service cleared, return to IDLE. Re-arbitration occurs on the following IDLE cycle.
  - int_ack is ignored.
- Latency: irq_in edge to int_req=1 is SYNC_STAGES+2 posedges with the FSM in IDLE (2 sync, 1 pending, 1 FSM). Minimum gap from int_eoi to the next int_req is 2 cycles.
- Config writes:
  - Mask and mode take effect on the next cycle.
  - Changing mode[i] clears pending[i].
  - Writes to addr 3 are ignored.
- Reset mid-operation: all state returns to reset values at once. int_req drops asynchronously.

Decomposition:
- Package mips_int_pkg holds:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2).
  - Config address constants CFG_MASK, CFG_MODE, CFG_PEND, CFG_INSV.
- Sub-module mips_prio_enc: parametrised lowest-index-first priority encoder. Inputs a NUM_IRQ vector; outputs a valid bit and an ID_W index.

Test Plan:
- Reset, mask=0xFF, mode=0xFF, pulse irq_in[3] for 1 cycle → int_req=1 at posedge 4 after the pulse, int_id=3. Ack → pending=0x00, in_service=0x08. Eoi → in_service=0x00.
- irq_in[5] and irq_in[2] rise in the same cycle → int_id=2 first. After ack and eoi → second request with int_id=5.
- In REQ with int_id=6, write mask=0xBF → int_req drops next cycle, state IDLE, no ack required. Pending bit 6 remains set; unmasking re-requests int_id=6.
- Level mode (mode=0x00), hold irq_in[1]=1 through eoi → a new request with int_id=1 appears 2 cycles after eoi. Drop irq_in[1] before eoi → no re-request.
- Edge on irq_in[4] in the same cycle as a W1C write of 0x10 → pending[4] remains 1 (set wins).
- Assert rst while in SERVICE → int_req=0, in_service=0, mask=0, mode=0xFF immediately. No request after release until the mask is rewritten.

Source files
------------

// File: rtl/mips_int_ctrl_pkg.sv
// Shared types for the mips_int_ctrl interrupt controller.
// Holds the FSM state encoding and the config register map.
package mips_int_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } int_state_t;

   localparam logic [1:0] CFG_MASK = 2'd0;
   localparam logic [1:0] CFG_MODE = 2'd1;
   localparam logic [1:0] CFG_PEND = 2'd2;
   localparam logic [1:0] CFG_INSV = 2'd3;

endpackage

// File: rtl/mips_int_ctrl_if.sv
// CPU-side bus of the interrupt controller: config register port
// plus the req/ack/eoi handshake. master = CPU, slave = controller.
interface mips_int_ctrl_if #(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = 3
);
   logic               cfg_we;
   logic [1:0]         cfg_addr;
   logic [NUM_IRQ-1:0] cfg_wdata;
   logic [NUM_IRQ-1:0] cfg_rdata;
   logic               int_req;
   logic [ID_W-1:0]    int_id;
   logic               int_ack;
   logic               int_eoi;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, int_ack, int_eoi,
      input  cfg_rdata, int_req, int_id
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, int_ack, int_eoi,
      output cfg_rdata, int_req, int_id
   );
endinterface

// File: rtl/mips_int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder.
// Ports: vec (request vector) -> valid (any set), idx (winner).
module mips_prio_enc #(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = 3
) (
   input  logic [NUM_IRQ-1:0] vec,
   output logic               valid,
   output logic [ID_W-1:0]    idx
);

   always_comb begin
      valid = |vec;
      idx   = '0;
      // Scan downwards so the lowest set index is written last.
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (vec[i]) idx = ID_W'(i);
      end
   end

endmodule

// File: rtl/mips_int_ctrl.sv
// Multi-source interrupt controller: sync, edge/level pending, mask,
// fixed priority, req/ack/eoi FSM. Ports: clk, rst, irq_in, bus (slave).
module mips_int_ctrl
   import mips_int_pkg::*;
#(
   parameter int NUM_IRQ     = 8,
   parameter int ID_W        = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   mips_int_ctrl_if.slave     bus
);

   logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0] s, s_d;
   logic [NUM_IRQ-1:0] mask_q, mode_q, pend_q, insv_q;
   logic [NUM_IRQ-1:0] pend_d, eligible;
   logic [NUM_IRQ-1:0] ack_vec, w1c_vec, edge_nxt;
   logic [ID_W-1:0]    win_id;
   logic               win_vld;
   logic               ack_fire;
   int_state_t         state;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         s_d <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         s_d <= s;
      end
   end

   assign ack_fire = (state == REQ) && bus.int_ack;
   assign ack_vec  = ack_fire ? (NUM_IRQ'(1) << bus.int_id) : '0;
   assign w1c_vec  = (bus.cfg_we && bus.cfg_addr == CFG_PEND)
                     ? bus.cfg_wdata : '0;
   // A fresh rising edge beats any clear in the same cycle.
   assign edge_nxt = (s & ~s_d) | (pend_q & ~(ack_vec | w1c_vec));

   always_comb begin
      pend_d = (mode_q & edge_nxt) | (~mode_q & s);
      if (bus.cfg_we && bus.cfg_addr == CFG_MODE)
         pend_d = pend_d & ~(bus.cfg_wdata ^ mode_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q <= '0;
         mode_q <= '1;
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
         if (bus.cfg_we && bus.cfg_addr == CFG_MASK)
            mask_q <= bus.cfg_wdata;
         if (bus.cfg_we && bus.cfg_addr == CFG_MODE)
            mode_q <= bus.cfg_wdata;
      end
   end

   assign eligible = pend_q & mask_q;

   mips_prio_enc #(
      .NUM_IRQ (NUM_IRQ),
      .ID_W    (ID_W)
   ) u_prio (
      .vec   (eligible),
      .valid (win_vld),
      .idx   (win_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bus.int_req <= 1'b0;
         bus.int_id  <= '0;
         insv_q      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (win_vld) begin
                  state       <= REQ;
                  bus.int_req <= 1'b1;
                  bus.int_id  <= win_id;
               end
            end
            REQ: begin
               if (bus.int_ack) begin
                  state       <= SERVICE;
                  bus.int_req <= 1'b0;
                  insv_q      <= insv_q | ack_vec;
               end else if (!eligible[bus.int_id]) begin
                  state       <= IDLE;
                  bus.int_req <= 1'b0;
               end
            end
            SERVICE: begin
               if (bus.int_eoi) begin
                  state  <= IDLE;
                  insv_q <= '0;
               end
            end
            default: begin
               state       <= IDLE;
               bus.int_req <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      bus.cfg_rdata = '0;
      case (bus.cfg_addr)
         CFG_MASK: bus.cfg_rdata = mask_q;
         CFG_MODE: bus.cfg_rdata = mode_q;
         CFG_PEND: bus.cfg_rdata = pend_q;
         CFG_INSV: bus.cfg_rdata = insv_q;
         default:  bus.cfg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_mips_int_ctrl.sv
// Directed bench for mips_int_ctrl: config register table plus
// hand-written request/ack/eoi, level, W1C and reset sequences.
module tb_mips_int_ctrl;
   import mips_int_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] irq = '0;
   int         nchk = 0;
   int         nerr = 0;

   mips_int_ctrl_if #(.NUM_IRQ(8), .ID_W(3)) bus ();

   mips_int_ctrl #(
      .NUM_IRQ     (8),
      .ID_W        (3),
      .SYNC_STAGES (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .irq_in (irq),
      .bus    (bus.slave)
   );

   always #10 clk = ~clk;

   typedef struct {
      string      name;
      logic       we;
      logic [1:0] addr;
      logic [7:0] wdata;
      logic [1:0] raddr;
      logic [7:0] exp;
   } cfg_vec_t;

   cfg_vec_t tbl [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reg(input string nm, input logic [1:0] a,
                          input logic [7:0] exp);
      bus.cfg_addr = a;
      #1;
      chk(nm, {24'd0, bus.cfg_rdata}, {24'd0, exp});
   endtask

   task automatic chk_req(input string nm, input logic r,
                          input logic [2:0] id);
      chk({nm, ".req"}, {31'd0, bus.int_req}, {31'd0, r});
      if (r) chk({nm, ".id"}, {29'd0, bus.int_id}, {29'd0, id});
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_wdata = d;
      tick();
      bus.cfg_we    = 1'b0;
   endtask

   task automatic ack();
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
   endtask

   task automatic eoi();
      bus.int_eoi = 1'b1;
      tick();
      bus.int_eoi = 1'b0;
   endtask

   task automatic pulse(input logic [7:0] v);
      irq = v;
      tick();
      irq = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = CFG_MASK;
      bus.cfg_wdata = '0;
      bus.int_ack   = 1'b0;
      bus.int_eoi   = 1'b0;

      tbl[0] = '{"mask_a5",   1'b1, CFG_MASK, 8'hA5, CFG_MASK, 8'hA5};
      tbl[1] = '{"mode_3c",   1'b1, CFG_MODE, 8'h3C, CFG_MODE, 8'h3C};
      tbl[2] = '{"insv_ro",   1'b1, CFG_INSV, 8'hFF, CFG_INSV, 8'h00};
      tbl[3] = '{"pend_w1c",  1'b1, CFG_PEND, 8'hFF, CFG_PEND, 8'h00};
      tbl[4] = '{"mask_keep", 1'b0, CFG_MASK, 8'h11, CFG_MASK, 8'hA5};
      tbl[5] = '{"mask_00",   1'b1, CFG_MASK, 8'h00, CFG_MASK, 8'h00};
      tbl[6] = '{"mode_ff",   1'b1, CFG_MODE, 8'hFF, CFG_MODE, 8'hFF};

      // reset values
      tick();
      tick();
      chk_req("rst", 1'b0, 3'd0);
      chk("rst.id", {29'd0, bus.int_id}, 32'd0);
      chk_reg("rst.mask", CFG_MASK, 8'h00);
      chk_reg("rst.mode", CFG_MODE, 8'hFF);
      chk_reg("rst.pend", CFG_PEND, 8'h00);
      chk_reg("rst.insv", CFG_INSV, 8'h00);
      rst = 1'b0;
      tick();

      // config register table
      for (int i = 0; i < 7; i++) begin
         bus.cfg_we    = tbl[i].we;
         bus.cfg_addr  = tbl[i].addr;
         bus.cfg_wdata = tbl[i].wdata;
         tick();
         bus.cfg_we = 1'b0;
         chk_reg(tbl[i].name, tbl[i].raddr, tbl[i].exp);
      end
      chk_req("tbl_idle", 1'b0, 3'd0);

      // single edge source, latency 4 posedges
      wr(CFG_MASK, 8'hFF);
      pulse(8'h08);
      tick();
      tick();
      chk_req("t1.p3", 1'b0, 3'd0);
      tick();
      chk_req("t1.p4", 1'b1, 3'd3);
      ack();
      chk_req("t1.ack", 1'b0, 3'd0);
      chk_reg("t1.pend", CFG_PEND, 8'h00);
      chk_reg("t1.insv", CFG_INSV, 8'h08);
      eoi();
      chk_reg("t1.eoi", CFG_INSV, 8'h00);
      tick();
      chk_req("t1.quiet", 1'b0, 3'd0);

      // two simultaneous sources, lowest index first
      pulse(8'h24);
      tick();
      tick();
      tick();
      chk_req("t2.first", 1'b1, 3'd2);
      ack();
      chk_reg("t2.pend", CFG_PEND, 8'h20);
      chk_reg("t2.insv", CFG_INSV, 8'h04);
      eoi();
      chk_req("t2.gap", 1'b0, 3'd0);
      tick();
      chk_req("t2.second", 1'b1, 3'd5);
      ack();
      eoi();

      // withdrawal by masking while in REQ
      pulse(8'h40);
      tick();
      tick();
      tick();
      chk_req("t3.req", 1'b1, 3'd6);
      wr(CFG_MASK, 8'hBF);
      chk_req("t3.hold", 1'b1, 3'd6);
      tick();
      chk_req("t3.wdraw", 1'b0, 3'd0);
      chk_reg("t3.pend", CFG_PEND, 8'h40);
      wr(CFG_MASK, 8'hFF);
      tick();
      chk_req("t3.rereq", 1'b1, 3'd6);
      ack();
      eoi();

      // level mode
      wr(CFG_MODE, 8'h00);
      irq = 8'h02;
      tick();
      tick();
      tick();
      tick();
      chk_req("t4.req", 1'b1, 3'd1);
      ack();
      chk_reg("t4.pend", CFG_PEND, 8'h02);
      eoi();
      chk_req("t4.gap", 1'b0, 3'd0);
      tick();
      chk_req("t4.rereq", 1'b1, 3'd1);
      ack();
      irq = '0;
      tick();
      tick();
      tick();
      chk_reg("t4.drop", CFG_PEND, 8'h00);
      eoi();
      tick();
      tick();
      chk_req("t4.noreq", 1'b0, 3'd0);

      // edge coinciding with W1C: set wins; W1C alone withdraws
      wr(CFG_MODE, 8'hFF);
      irq = 8'h10;
      tick();
      tick();
      wr(CFG_PEND, 8'h10);
      chk_reg("t5.setwin", CFG_PEND, 8'h10);
      tick();
      chk_req("t5.req", 1'b1, 3'd4);
      wr(CFG_PEND, 8'h10);
      chk_reg("t5.clr", CFG_PEND, 8'h00);
      tick();
      chk_req("t5.wdraw", 1'b0, 3'd0);
      irq = '0;

      // reset during SERVICE
      pulse(8'h01);
      tick();
      tick();
      tick();
      chk_req("t6.req", 1'b1, 3'd0);
      ack();
      chk_reg("t6.insv", CFG_INSV, 8'h01);
      rst = 1'b1;
      #1;
      chk_req("t6.rst", 1'b0, 3'd0);
      chk_reg("t6.insv0", CFG_INSV, 8'h00);
      chk_reg("t6.mask0", CFG_MASK, 8'h00);
      chk_reg("t6.modeff", CFG_MODE, 8'hFF);
      tick();
      rst = 1'b0;
      pulse(8'h01);
      for (int i = 0; i < 5; i++) tick();
      chk_req("t6.masked", 1'b0, 3'd0);
      chk_reg("t6.pend", CFG_PEND, 8'h01);
      wr(CFG_MASK, 8'hFF);
      tick();
      chk_req("t6.unmask", 1'b1, 3'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
